frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/frame_capture_ctrl.sv | 73 +++++++
 tb/tb_frame_capture_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on request, writes one video frame into a frame buffer; CAPTURE_DECIMATE_EN enables 2x decimation
module frame_capture_ctrl #(
  parameter int HCOUNT_WIDTH = 9,
  parameter int VCOUNT_WIDTH = 8,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    arm_in,
  input  logic                    continuous_in,
  input  logic                    abort_in,
  input  logic                    pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
  input  logic [15:0]             pixel_data_in,
  output logic                    bram_we_out,
  output logic [ADDR_WIDTH-1:0]   bram_addr_out,
  output logic [15:0]             bram_data_out,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic [7:0]              frame_count_out,
  output logic                    error_out
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
`ifdef CAPTURE_DECIMATE_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam int W = H_ACTIVE >> S;
  // last accepted coordinate: largest on-grid value inside the window
  localparam int LH = ((H_ACTIVE - 1) >> S) << S;
  localparam int LV = ((V_ACTIVE - 1) >> S) << S;
  state_t state, state_n;
  logic fs, keep, accept, last, restart;
  logic [ADDR_WIDTH-1:0] addr;
  always_comb begin
    fs = pixel_valid_in && pixel_hcount_in == '0 && pixel_vcount_in == '0;
    keep = 32'(pixel_hcount_in) < H_ACTIVE && 32'(pixel_vcount_in) < V_ACTIVE &&
           (S == 0 || (!pixel_hcount_in[0] && !pixel_vcount_in[0]));
    accept = pixel_valid_in && keep && !abort_in && (state == CAPTURE || (state == ARMED && fs));
    last = accept && 32'(pixel_hcount_in) == LH && 32'(pixel_vcount_in) == LV;
    restart = state == CAPTURE && fs && !abort_in;
    addr = ADDR_WIDTH'(32'(pixel_vcount_in >> S) * W + 32'(pixel_hcount_in >> S));
    state_n = abort_in ? IDLE :
              state == IDLE ? ((arm_in || continuous_in) ? ARMED : IDLE) :
              state == ARMED ? (accept ? (last ? DONE : CAPTURE) : ARMED) :
              state == CAPTURE ? (last ? DONE : CAPTURE) :
              (continuous_in ? ARMED : IDLE);
  end
  assign busy_out = state == ARMED || state == CAPTURE;
  assign frame_done_out = state == DONE;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      bram_we_out <= 1'b0;
      bram_addr_out <= '0;
      bram_data_out <= '0;
      frame_count_out <= '0;
      error_out <= 1'b0;
    end else begin
      state <= state_n;
      bram_we_out <= accept;
      if (accept) begin
        bram_addr_out <= addr;
        bram_data_out <= pixel_data_in;
      end
      if (state == DONE) frame_count_out <= frame_count_out + 8'd1;
      if (restart) error_out <= 1'b1;
    end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: scoreboard bench for frame_capture_ctrl on a 4x3 window
module tb_frame_capture_ctrl;
  logic clk = 0, rst = 1, arm = 0, cont = 0, abort = 0, pv = 0;
  logic [8:0] hc = 0;
  logic [7:0] vc = 0;
  logic [15:0] pd = 0;
  logic we, busy, done, err;
  logic [16:0] addr;
  logic [15:0] data;
  logic [7:0] cnt;
  logic [32:0] q[$];
  int n_cmp = 0, n_err = 0, done_cnt = 0, n_wr = 0, exp_wr = 0, tag = 0;
  int d0, w0, e0;
  always #5 clk = ~clk;
  frame_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(3)) u (
    .clk_in(clk), .rst_in(rst), .arm_in(arm), .continuous_in(cont), .abort_in(abort),
    .pixel_valid_in(pv), .pixel_hcount_in(hc), .pixel_vcount_in(vc), .pixel_data_in(pd),
    .bram_we_out(we), .bram_addr_out(addr), .bram_data_out(data), .busy_out(busy),
    .frame_done_out(done), .frame_count_out(cnt), .error_out(err)
  );
  function automatic bit keep(int h, int v);
`ifdef CAPTURE_DECIMATE_EN
    return h < 4 && v < 3 && h % 2 == 0 && v % 2 == 0;
`else
    return h < 4 && v < 3;
`endif
  endfunction
  function automatic int aof(int h, int v);
`ifdef CAPTURE_DECIMATE_EN
    return (v / 2) * 2 + h / 2;
`else
    return v * 4 + h;
`endif
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic pix(int h, int v, bit en);
    logic [15:0] d;
    d = 16'(tag * 256 + v * 16 + h);
    pv = 1; hc = 9'(h); vc = 8'(v); pd = d;
    if (en && keep(h, v)) begin
      q.push_back({17'(aof(h, v)), d});
      exp_wr++;
    end
    @(posedge clk); #1 pv = 0;
  endtask
  task automatic frame(int hm, int vm, int s);
    tag++;
    for (int i = s; i < hm * vm; i++) pix(i % hm, i / hm, 1);
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_arm();
    arm = 1; idle(1); arm = 0;
  endtask
  task automatic do_reset();
    rst = 1; #2 rst = 0;
    idle(1);
  endtask
  task automatic chk_zero(string nm);
    chk({nm, " we"}, we, 0); chk({nm, " addr"}, addr, 0); chk({nm, " data"}, data, 0);
    chk({nm, " busy"}, busy, 0); chk({nm, " done"}, done, 0); chk({nm, " count"}, cnt, 0);
    chk({nm, " error"}, err, 0);
  endtask
  initial begin
    fork
      forever begin
        logic [32:0] e;
        @(negedge clk);
        if (we) begin
          n_wr++;
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected write: addr %0d data %0h, none expected", addr, data);
          end else begin
            e = q.pop_front();
            chk("write addr", addr, e[32:16]);
            chk("write data", data, e[15:0]);
          end
        end
        if (done) done_cnt++;
      end
      begin
        #2 chk_zero("reset");
        #1 rst = 0;
        idle(1);
        pix(0, 0, 0);
        idle(2);
        chk("idle drop busy", busy, 0);
        chk("idle drop writes", n_wr, 0);
        pulse_arm();
        chk("armed busy", busy, 1);
        pix(1, 0, 0);
        frame(4, 3, 0);
        chk("done pulse", done, 1);
        chk("done busy", busy, 0);
        idle(2);
        chk("single count", cnt, 1);
        chk("single done", done_cnt, 1);
        chk("single writes", n_wr, exp_wr);
        chk("single busy", busy, 0);
        d0 = done_cnt;
        pulse_arm();
        frame(6, 5, 0);
        idle(2);
        chk("clip done", done_cnt - d0, 1);
        chk("clip count", cnt, 2);
        chk("clip writes", n_wr, exp_wr);
        chk("clip queue", q.size(), 0);
        do_reset();
        d0 = done_cnt; w0 = n_wr; e0 = exp_wr;
        cont = 1;
        idle(1);
        for (int k = 0; k < 3; k++) begin
          frame(4, 3, 0);
          idle(2);
          chk("cont busy gap", busy, 1);
        end
        cont = 0;
        chk("cont count", cnt, 3);
        chk("cont done", done_cnt - d0, 3);
        chk("cont writes", n_wr - w0, exp_wr - e0);
`ifndef CAPTURE_DECIMATE_EN
        chk("cont write total", n_wr - w0, 36);
`endif
        abort = 1; idle(1); abort = 0;
        chk("cont abort busy", busy, 0);
        do_reset();
        d0 = done_cnt;
        pulse_arm();
        tag++;
        for (int i = 0; i < 6; i++) pix(i % 4, i / 4, 1);
        chk("short no error yet", err, 0);
        frame(4, 3, 0);
        idle(2);
        chk("short error", err, 1);
        chk("short done", done_cnt - d0, 1);
        chk("short count", cnt, 1);
        do_reset();
        d0 = done_cnt;
        pulse_arm();
        tag++;
        for (int i = 0; i < 6; i++) pix(i % 4, i / 4, 1);
        abort = 1;
        pix(2, 1, 0);
        abort = 0;
        chk("abort busy", busy, 0);
        pix(3, 1, 0);
        idle(2);
        chk("abort done", done_cnt - d0, 0);
        chk("abort count", cnt, 0);
        chk("abort error", err, 0);
        arm = 1; abort = 1;
        idle(1);
        arm = 0; abort = 0;
        chk("abort over arm", busy, 0);
        pulse_arm();
        tag++;
        pix(0, 0, 1);
        pix(1, 0, 1);
        @(negedge clk);
        #1 rst = 1;
        #1 chk_zero("mid reset");
        rst = 0;
        idle(1);
        d0 = done_cnt;
        pulse_arm();
        frame(4, 3, 0);
        idle(2);
        chk("after reset done", done_cnt - d0, 1);
        chk("after reset count", cnt, 1);
        chk("final queue", q.size(), 0);
        chk("final writes", n_wr, exp_wr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join_any
  end
endmodule
